trig_window: RTL

Trigger-gated window extractor that sits directly downstream of the sample delay line in the FIR trigger path. It consumes the delayed sample-word stream and a one-cycle trigger strobe from the FIR discriminator. On an accepted trigger it emits a fixed-length window of words, framed with start and end flags. A post-window holdoff follows, during which triggers are rejected and counted as missed.

---
 rtl/trig_window_pkg.sv | 16 +
 rtl/trig_window_sat_counter.sv | 22 ++
 rtl/trig_window.sv | 110 +++++++++++
 3 files changed

// File: rtl/trig_window_pkg.sv
// Shared definitions for the trigger window path.
// FSM encodings and counter widths, reused by the readout stage.
package trig_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int TRIG_CNT_W = 32;
    localparam int MISS_CNT_W = 16;
    localparam int WCNT_W     = 16;
    localparam int HCNT_W     = 16;

endpackage

// File: rtl/trig_window_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter
    import trig_window_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/trig_window.sv
// Trigger-gated window extractor on the delayed sample stream.
// Emits WINDOW framed words per accepted trigger, then holds off.
module trig_window
    import trig_window_pkg::*;
#(
    parameter int BITS    = 56,
    parameter int WINDOW  = 64,
    parameter int HOLDOFF = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BITS-1:0]       d_in,
    input  logic                  trig_in,
    input  logic                  arm,
    output logic [BITS-1:0]       d_out,
    output logic                  d_valid,
    output logic                  sof,
    output logic                  eof,
    output logic                  busy,
    output logic [TRIG_CNT_W-1:0] trig_count,
    output logic [MISS_CNT_W-1:0] missed_count
);

    localparam logic [WCNT_W-1:0] WIN_LAST =
        WCNT_W'(WINDOW - 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST =
        HCNT_W'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
    localparam state_t END_ST =
        (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic [HCNT_W-1:0] hcnt;
    logic              accept;
    logic              miss;

    assign accept = trig_in && arm && (state == ST_IDLE);
    assign miss   = trig_in && (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            hcnt    <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
            sof     <= 1'b0;
            eof     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            d_out   <= '0;
            d_valid <= 1'b0;
            sof     <= 1'b0;
            eof     <= 1'b0;
            // Stays high through the cycle after the last holdoff edge
            busy    <= (state != ST_IDLE) || accept;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        d_out   <= d_in;
                        d_valid <= 1'b1;
                        sof     <= 1'b1;
                        eof     <= (WINDOW == 1);
                        wcnt    <= WCNT_W'(1);
                        hcnt    <= '0;
                        state   <= (WINDOW == 1) ? END_ST : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    d_out   <= d_in;
                    d_valid <= 1'b1;
                    wcnt    <= wcnt + 1'b1;
                    if (wcnt == WIN_LAST) begin
                        eof   <= 1'b1;
                        hcnt  <= '0;
                        state <= END_ST;
                    end
                end
                ST_HOLDOFF: begin
                    hcnt <= hcnt + 1'b1;
                    if (hcnt == HOLD_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (TRIG_CNT_W)
    ) u_trig_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (accept),
        .count (trig_count)
    );

    sat_counter #(
        .WIDTH (MISS_CNT_W)
    ) u_miss_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (miss),
        .count (missed_count)
    );

endmodule
